// File: rtl/cam_ternary_pipe.sv
// cam_ternary_pipe: ternary CAM with per-slice care masks, 2-stage search pipeline and sequential flush.
// Optional CAM_MATCH_COUNT_EN adds a registered popcount of the hit vector (match_count).
module cam_ternary_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int SLICE_WIDTH = 4,
  localparam int DEPTH = 2 ** ADDR_WIDTH,
  localparam int SLICES = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_valid,
  output logic                  write_ready,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [SLICES-1:0]     write_mask,
  input  logic                  write_delete,
  input  logic                  search_valid,
  output logic                  search_ready,
  input  logic [DATA_WIDTH-1:0] search_data,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  match_valid,
  output logic                  match,
  output logic                  match_multi,
  output logic [DEPTH-1:0]      match_many,
  output logic [DEPTH-1:0]      match_single,
  output logic [ADDR_WIDTH-1:0] match_addr
`ifdef CAM_MATCH_COUNT_EN
  ,output logic [ADDR_WIDTH:0]  match_count
`endif
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nx;
  logic up, wr, sr, s1_v;
  logic [ADDR_WIDTH-1:0] cnt, enc;
  logic [DATA_WIDTH-1:0] key [DEPTH];
  logic [SLICES-1:0] mask [DEPTH];
  logic [DEPTH-1:0] valid, hit, s1_many;
  // up holds the readys low until the first edge after reset release
  assign write_ready = up && state == IDLE;
  assign search_ready = up && state == IDLE;
  assign flush_busy = state == FLUSH;
  assign wr = write_valid && write_ready;
  assign sr = search_valid && search_ready;
  always_comb state_nx = state == IDLE ? (up && flush_req ? FLUSH : IDLE) : (cnt == '1 ? IDLE : FLUSH);
  for (genvar i = 0; i < DEPTH; i++) begin : g_e
    logic [DATA_WIDTH-1:0] care;
    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_b
      assign care[b] = mask[i][b / SLICE_WIDTH];
    end
    assign hit[i] = valid[i] && ((key[i] ^ search_data) & care) == '0;
  end
  always_comb begin
    enc = '0;
    for (int k = DEPTH - 1; k >= 0; k--) if (s1_many[k]) enc = ADDR_WIDTH'(k);
  end
`ifdef CAM_MATCH_COUNT_EN
  logic [ADDR_WIDTH:0] pc;
  always_comb begin
    pc = '0;
    for (int k = 0; k < DEPTH; k++) pc = pc + (ADDR_WIDTH + 1)'(s1_many[k]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) match_count <= '0;
    else if (s1_v) match_count <= pc;
`endif
  always_ff @(posedge clk)
    if (wr && !write_delete) begin
      key[write_addr] <= write_data;
      mask[write_addr] <= write_mask;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      up <= 1'b0;
      cnt <= '0;
      valid <= '0;
      s1_v <= 1'b0;
      s1_many <= '0;
      match_valid <= 1'b0;
      match <= 1'b0;
      match_multi <= 1'b0;
      match_many <= '0;
      match_single <= '0;
      match_addr <= '0;
    end else begin
      up <= 1'b1;
      state <= state_nx;
      cnt <= state == FLUSH ? cnt + 1'b1 : '0;
      if (state == FLUSH) valid[cnt] <= 1'b0;
      else if (wr) valid[write_addr] <= !write_delete;
      s1_v <= sr;
      if (sr) s1_many <= hit;
      match_valid <= s1_v;
      if (s1_v) begin
        match <= |s1_many;
        match_multi <= |(s1_many & (s1_many - DEPTH'(1)));
        match_many <= s1_many;
        match_single <= s1_many & (~s1_many + DEPTH'(1));
        match_addr <= enc;
      end
    end
endmodule

// File: tb/tb_cam_ternary_pipe.sv
// tb_cam_ternary_pipe: directed checks of reset, ternary match, delete ordering, flush and pipelining.
module tb_cam_ternary_pipe;
  logic clk = 1'b0, rst_n = 1'b0;
  logic write_valid = 0, write_ready, write_delete = 0;
  logic [4:0] write_addr = '0, match_addr;
  logic [63:0] write_data = '0, search_data = '0;
  logic [15:0] write_mask = '0;
  logic search_valid = 0, search_ready, flush_req = 0, flush_busy;
  logic match_valid, match, match_multi;
  logic [31:0] match_many, match_single;
`ifdef CAM_MATCH_COUNT_EN
  logic [5:0] match_count;
`endif
  int cmp = 0, bad = 0;

  cam_ternary_pipe dut (
    .clk(clk), .rst_n(rst_n), .write_valid(write_valid), .write_ready(write_ready),
    .write_addr(write_addr), .write_data(write_data), .write_mask(write_mask),
    .write_delete(write_delete), .search_valid(search_valid), .search_ready(search_ready),
    .search_data(search_data), .flush_req(flush_req), .flush_busy(flush_busy),
    .match_valid(match_valid), .match(match), .match_multi(match_multi),
    .match_many(match_many), .match_single(match_single), .match_addr(match_addr)
`ifdef CAM_MATCH_COUNT_EN
    , .match_count(match_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d, input logic [15:0] m, input logic del);
    write_valid = 1; write_addr = a; write_data = d; write_mask = m; write_delete = del;
    step();
    write_valid = 0; write_delete = 0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    cmp++; if ({match_valid, match, match_multi, match_many, match_single, match_addr} !== '0) begin bad++; $display("FAIL reset_outputs got %h want 0", {match_valid, match, match_multi, match_many, match_single, match_addr}); end
    cmp++; if ({write_ready, search_ready, flush_busy} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got %b want 000", {write_ready, search_ready, flush_busy}); end
    rst_n = 1;
    cmp++; if (write_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got %b want 0", write_ready); end
    step();
    cmp++; if ({write_ready, search_ready} !== 2'b11) begin bad++; $display("FAIL ready_after_release got %b want 11", {write_ready, search_ready}); end
    search_valid = 1; search_data = '0;
    step();
    search_valid = 0;
    cmp++; if (match_valid !== 1'b0) begin bad++; $display("FAIL empty_latency1 got %b want 0", match_valid); end
    step();
    cmp++; if ({match_valid, match, match_addr} !== 7'b1000000) begin bad++; $display("FAIL empty_search got %b want 1000000", {match_valid, match, match_addr}); end
    step();
    cmp++; if (match_valid !== 1'b0) begin bad++; $display("FAIL strobe_width got %b want 0", match_valid); end
  endtask

  task automatic test_exact_match();
    do_write(5'd3, 64'hDEAD_BEEF, 16'hFFFF, 0);
    search_valid = 1; search_data = 64'hDEAD_BEEF;
    step();
    search_valid = 0;
    step();
    cmp++; if ({match_valid, match, match_multi} !== 3'b110) begin bad++; $display("FAIL exact_flags got %b want 110", {match_valid, match, match_multi}); end
    cmp++; if (match_addr !== 5'd3) begin bad++; $display("FAIL exact_addr got %0d want 3", match_addr); end
    cmp++; if (match_single !== 32'h8) begin bad++; $display("FAIL exact_single got %h want 00000008", match_single); end
    step();
  endtask

  task automatic test_ternary();
    do_write(5'd5, 64'h1234_5678, 16'hFFFE, 0);
    do_write(5'd9, 64'h1234_567F, 16'hFFFF, 0);
    search_valid = 1; search_data = 64'h1234_567F;
    step();
    search_valid = 0;
    step();
    cmp++; if (match_many !== 32'h0000_0220) begin bad++; $display("FAIL tern_many got %h want 00000220", match_many); end
    cmp++; if ({match_valid, match, match_multi, match_addr} !== {3'b111, 5'd5}) begin bad++; $display("FAIL tern_enc got %b want 11100101", {match_valid, match, match_multi, match_addr}); end
    cmp++; if (match_single !== 32'h20) begin bad++; $display("FAIL tern_single got %h want 00000020", match_single); end
`ifdef CAM_MATCH_COUNT_EN
    cmp++; if (match_count !== 6'd2) begin bad++; $display("FAIL tern_count got %0d want 2", match_count); end
`endif
    step();
  endtask

  task automatic test_delete_same_cycle();
    write_valid = 1; write_addr = 5'd3; write_delete = 1;
    search_valid = 1; search_data = 64'hDEAD_BEEF;
    step();
    write_valid = 0; write_delete = 0;
    step();
    search_valid = 0;
    cmp++; if ({match_valid, match, match_addr} !== {2'b11, 5'd3}) begin bad++; $display("FAIL del_pre_write got %b want 1100011", {match_valid, match, match_addr}); end
    step();
    cmp++; if ({match_valid, match} !== 2'b10) begin bad++; $display("FAIL del_post got %b want 10", {match_valid, match}); end
    step();
  endtask

  task automatic test_flush();
    logic [63:0] keys [4];
    int n = 0;
    keys[0] = '0; keys[1] = 64'h1234_567F; keys[2] = 64'h1234_5600; keys[3] = 64'hFFFF_FFFF;
    do_write(5'd31, 64'hFFFF_FFFF, 16'hFFFF, 0);
    flush_req = 1; write_valid = 1; write_addr = 5'd0; write_data = '0; write_mask = 16'hFFFF;
    step();
    flush_req = 0; write_valid = 0;
    for (int k = 0; k < 100 && flush_busy; k++) begin
      cmp++; if ({write_ready, search_ready} !== 2'b00) begin bad++; $display("FAIL flush_ready cyc %0d got %b want 00", k, {write_ready, search_ready}); end
      n++;
      step();
    end
    cmp++; if (n !== 32) begin bad++; $display("FAIL flush_len got %0d want 32", n); end
    cmp++; if ({write_ready, search_ready, flush_busy} !== 3'b110) begin bad++; $display("FAIL flush_done got %b want 110", {write_ready, search_ready, flush_busy}); end
    for (int k = 0; k < 4; k++) begin
      search_valid = 1; search_data = keys[k];
      step();
      search_valid = 0;
      step();
      cmp++; if ({match_valid, match, match_many} !== {2'b10, 32'h0}) begin bad++; $display("FAIL flush_search%0d got %b/%h want 10/0", k, {match_valid, match}, match_many); end
    end
    step();
  endtask

  task automatic test_back_to_back();
    do_write(5'd7, 64'hAAAA, 16'hFFFF, 0);
    search_valid = 1; search_data = 64'hAAAA;
    step();
    search_data = 64'hBBBB; write_valid = 1; write_addr = 5'd8; write_data = 64'hBBBB; write_mask = 16'hFFFF;
    step();
    write_valid = 0;
    cmp++; if ({match_valid, match, match_addr} !== {2'b11, 5'd7}) begin bad++; $display("FAIL b2b_a got %b want 1100111", {match_valid, match, match_addr}); end
    step();
    search_valid = 0;
    cmp++; if ({match_valid, match} !== 2'b10) begin bad++; $display("FAIL b2b_b got %b want 10", {match_valid, match}); end
    step();
    cmp++; if ({match_valid, match, match_addr} !== {2'b11, 5'd8}) begin bad++; $display("FAIL b2b_c got %b want 1101000", {match_valid, match, match_addr}); end
    step();
    search_valid = 1; search_data = 64'hAAAA;
    step();
    search_data = 64'hBBBB;
    rst_n = 0;
    #1;
    search_valid = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) rst_n = 1;
      cmp++; if (match_valid !== 1'b0) begin bad++; $display("FAIL reset_drop cyc %0d got %b want 0", k, match_valid); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_ternary();
    test_delete_same_cycle();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
